// File: rtl/traffic_pkg.sv
// Purpose: shared light-code, tracker-state and direction-index definitions for the 4-way controller and monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

    localparam logic [1:0] RED     = 2'b00;
    localparam logic [1:0] GREEN   = 2'b01;
    localparam logic [1:0] YELLOW  = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    // Tracker last-colour state; low two bits match the light code for known colours.
    typedef enum logic [2:0] {
        ST_RED     = 3'b000,
        ST_GREEN   = 3'b001,
        ST_YELLOW  = 3'b010,
        ST_UNKNOWN = 3'b100
    } phase_e;

    localparam int NS      = 0;
    localparam int EW      = 1;
    localparam int SN      = 2;
    localparam int WE      = 3;
    localparam int NUM_DIR = 4;

    localparam int DWELL_W = 8;

    // Map a legal light code onto the tracker state; anything else is UNKNOWN.
    function automatic phase_e to_phase(input logic [1:0] code);
        phase_e p;
        case (code)
            RED:     p = ST_RED;
            GREEN:   p = ST_GREEN;
            YELLOW:  p = ST_YELLOW;
            default: p = ST_UNKNOWN;
        endcase
        return p;
    endfunction

    // A direction counts as "lit" when it shows green or yellow.
    function automatic logic is_lit(input logic [1:0] code);
        return (code == GREEN) || (code == YELLOW);
    endfunction

endpackage

// File: rtl/light_phase_tracker.sv
// Purpose: per-direction colour-sequence and dwell checker; emits single-cycle error/transition events.
// Latency: events are combinational from the current sample and registered state; the parent registers them.
// Backpressure: none, passive observer sampling every clock.
module light_phase_tracker
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 10,
    parameter int YELLOW_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light,
    output logic       seq_evt,
    output logic       timing_evt,
    output logic       illegal_evt,
    output logic       red_to_green
);

    localparam logic [DWELL_W-1:0] GREEN_DW  = DWELL_W'(GREEN_TICKS);
    localparam logic [DWELL_W-1:0] YELLOW_DW = DWELL_W'(YELLOW_TICKS);
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    phase_e               last, last_nxt;
    logic [DWELL_W-1:0]   dwell, dwell_nxt;
    // Set once the current colour was entered from a known colour, so its dwell is complete and checkable.
    logic                 timed, timed_nxt;

    // State register: synchronous active-low reset drops all history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last  <= ST_UNKNOWN;
            dwell <= '0;
            timed <= 1'b0;
        end else begin
            last  <= last_nxt;
            dwell <= dwell_nxt;
            timed <= timed_nxt;
        end
    end

    // Next-state and event decode for one observed sample.
    always_comb begin
        last_nxt     = last;
        dwell_nxt    = dwell;
        timed_nxt    = timed;
        seq_evt      = 1'b0;
        timing_evt   = 1'b0;
        illegal_evt  = 1'b0;
        red_to_green = 1'b0;

        if (light == ILLEGAL) begin
            illegal_evt = 1'b1;
            last_nxt    = ST_UNKNOWN;
            dwell_nxt   = '0;
            timed_nxt   = 1'b0;
        end else if (last == ST_UNKNOWN) begin
            // First colour after reset or an illegal code: partial dwell, accepted unchecked.
            last_nxt  = to_phase(light);
            dwell_nxt = DWELL_W'(1);
            timed_nxt = 1'b0;
        end else if (light == last[1:0]) begin
            // Saturate so an over-long dwell can never wrap back onto the target value.
            if (dwell != DWELL_MAX) begin
                dwell_nxt = dwell + DWELL_W'(1);
            end
        end else begin
            case (last)
                ST_GREEN: begin
                    seq_evt    = (light != YELLOW);
                    timing_evt = timed && (dwell != GREEN_DW);
                end
                ST_YELLOW: begin
                    seq_evt    = (light != RED);
                    timing_evt = timed && (dwell != YELLOW_DW);
                end
                ST_RED: begin
                    seq_evt      = (light != GREEN);
                    red_to_green = (light == GREEN);
                end
                default: ;
            endcase
            last_nxt  = to_phase(light);
            dwell_nxt = DWELL_W'(1);
            timed_nxt = 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Purpose: passive checker on the 4-way light bus: conflict, illegal code, sequence and dwell errors plus cycle count.
// Latency: all flags and cycle_count update one clock after the offending sample.
// Backpressure: none, drives no lights and never stalls the controller.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 10,
    parameter int YELLOW_TICKS = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_err,
    input  logic [1:0]       NS_light,
    input  logic [1:0]       EW_light,
    input  logic [1:0]       SN_light,
    input  logic [1:0]       WE_light,
    output logic             conflict_err,
    output logic             illegal_err,
    output logic             seq_err,
    output logic             timing_err,
    output logic [3:0]       err_dir,
    output logic [CNT_W-1:0] cycle_count
);

    logic [1:0]         light [NUM_DIR];
    logic [NUM_DIR-1:0] seq_evt, timing_evt, illegal_evt, r2g_evt, lit;
    logic [NUM_DIR-1:0] dir_evt;
    logic [2:0]         n_lit;
    logic               conflict_evt;

    assign light[NS] = NS_light;
    assign light[EW] = EW_light;
    assign light[SN] = SN_light;
    assign light[WE] = WE_light;

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_trk
        light_phase_tracker #(
            .GREEN_TICKS  (GREEN_TICKS),
            .YELLOW_TICKS (YELLOW_TICKS)
        ) u_trk (
            .clk          (clk),
            .reset        (reset),
            .light        (light[d]),
            .seq_evt      (seq_evt[d]),
            .timing_evt   (timing_evt[d]),
            .illegal_evt  (illegal_evt[d]),
            .red_to_green (r2g_evt[d])
        );
    end

    // Conflict detection and per-direction event merge for the current sample.
    always_comb begin
        n_lit = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            lit[d] = is_lit(light[d]);
            n_lit  = n_lit + 3'(lit[d]);
        end
        conflict_evt = (n_lit > 3'd1);
        dir_evt      = seq_evt | timing_evt | illegal_evt | (lit & {NUM_DIR{conflict_evt}});
    end

    // Sticky flags (new errors override a same-cycle clear) and the NS cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_err <= 1'b0;
            illegal_err  <= 1'b0;
            seq_err      <= 1'b0;
            timing_err   <= 1'b0;
            err_dir      <= '0;
            cycle_count  <= '0;
        end else begin
            conflict_err <= (conflict_err & ~clr_err) | conflict_evt;
            illegal_err  <= (illegal_err  & ~clr_err) | (|illegal_evt);
            seq_err      <= (seq_err      & ~clr_err) | (|seq_evt);
            timing_err   <= (timing_err   & ~clr_err) | (|timing_evt);
            err_dir      <= (err_dir & ~{NUM_DIR{clr_err}}) | dir_evt;
            cycle_count  <= cycle_count + CNT_W'(r2g_evt[NS]);
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    typedef struct packed {
        logic       conf;
        logic       ill;
        logic       seq;
        logic       tim;
        logic [3:0] dir;
        logic [7:0] cnt;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       clr_err;
    logic [1:0] NS_light, EW_light, SN_light, WE_light;
    logic       conflict_err, illegal_err, seq_err, timing_err;
    logic [3:0] err_dir;
    logic [7:0] cycle_count;

    traffic_light_monitor #(
        .GREEN_TICKS  (10),
        .YELLOW_TICKS (2),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clr_err      (clr_err),
        .NS_light     (NS_light),
        .EW_light     (EW_light),
        .SN_light     (SN_light),
        .WE_light     (WE_light),
        .conflict_err (conflict_err),
        .illegal_err  (illegal_err),
        .seq_err      (seq_err),
        .timing_err   (timing_err),
        .err_dir      (err_dir),
        .cycle_count  (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obs_t  exp_q [$];
    string name_q [$];
    int    n_vec  = 0;
    int    n_miss = 0;

    // Expected state after the next clock edge, maintained by the stimulus.
    logic       x_conf, x_ill, x_seq, x_tim;
    logic [3:0] x_dir;
    logic [7:0] x_cnt;

    obs_t  m_exp, m_got;
    string m_name;

    // Monitor: after every edge, pop one expected observation and compare.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_got  = '{conflict_err, illegal_err, seq_err, timing_err, err_dir, cycle_count};
            n_vec++;
            if (m_got !== m_exp) begin
                n_miss++;
                $display("FAIL %s: got conf=%0b ill=%0b seq=%0b tim=%0b dir=%b cnt=%0d, want conf=%0b ill=%0b seq=%0b tim=%0b dir=%b cnt=%0d",
                         m_name, m_got.conf, m_got.ill, m_got.seq, m_got.tim, m_got.dir, m_got.cnt,
                         m_exp.conf, m_exp.ill, m_exp.seq, m_exp.tim, m_exp.dir, m_exp.cnt);
            end
        end
    end

    task automatic clear_flags();
        x_conf = 1'b0; x_ill = 1'b0; x_seq = 1'b0; x_tim = 1'b0; x_dir = 4'b0000;
    endtask

    // Drive one sample at the falling edge and queue the expected post-edge outputs.
    task automatic step(input logic [1:0] ns, input logic [1:0] ew, input logic [1:0] sn,
                        input logic [1:0] we, input logic clr, input logic rst, input string nm);
        NS_light = ns; EW_light = ew; SN_light = sn; WE_light = we;
        clr_err  = clr;
        reset    = rst;
        exp_q.push_back('{x_conf, x_ill, x_seq, x_tim, x_dir, x_cnt});
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic all_red(input string nm);
        step(RED, RED, RED, RED, 1'b0, 1'b1, nm);
    endtask

    // One legal green/yellow phase for direction d with every other direction red.
    task automatic rot_dir(input int d, input string nm);
        logic [1:0] l [4];
        for (int i = 0; i < 4; i++) l[i] = RED;
        l[d] = GREEN;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 && d == NS) x_cnt = x_cnt + 8'd1;
            step(l[0], l[1], l[2], l[3], 1'b0, 1'b1, nm);
        end
        l[d] = YELLOW;
        for (int i = 0; i < 2; i++) step(l[0], l[1], l[2], l[3], 1'b0, 1'b1, nm);
    endtask

    initial begin
        reset = 1'b0; clr_err = 1'b0;
        NS_light = RED; EW_light = RED; SN_light = RED; WE_light = RED;
        clear_flags();
        x_cnt = 8'd0;
        @(negedge clk);

        // Reset held with all red, then idle red.
        step(RED, RED, RED, RED, 1'b0, 1'b0, "reset");
        step(RED, RED, RED, RED, 1'b0, 1'b0, "reset");
        all_red("idle_red");
        all_red("idle_red");

        // Three legal rotations NS, EW, SN, WE: no errors, count reaches 3.
        for (int c = 0; c < 3; c++)
            for (int d = 0; d < 4; d++) rot_dir(d, "rotation");
        all_red("rotation_end");

        // NS green only 9 clocks: timing error on the yellow sample, sticky until cleared.
        x_cnt = x_cnt + 8'd1;
        for (int i = 0; i < 9; i++) step(GREEN, RED, RED, RED, 1'b0, 1'b1, "ns_green9");
        x_tim = 1'b1; x_dir = 4'b0001;
        step(YELLOW, RED, RED, RED, 1'b0, 1'b1, "ns_short_green");
        step(YELLOW, RED, RED, RED, 1'b0, 1'b1, "timing_sticky");
        all_red("timing_sticky");
        all_red("timing_sticky");
        clear_flags();
        step(RED, RED, RED, RED, 1'b1, 1'b1, "clr_timing");

        // EW green while NS yellow: conflict on both directions.
        x_cnt = x_cnt + 8'd1;
        for (int i = 0; i < 10; i++) step(GREEN, RED, RED, RED, 1'b0, 1'b1, "ns_green10");
        x_conf = 1'b1; x_dir = 4'b0011;
        step(YELLOW, GREEN, RED, RED, 1'b0, 1'b1, "conflict");
        step(YELLOW, GREEN, RED, RED, 1'b0, 1'b1, "conflict");
        // EW green->red (seq) after 2 clocks (timing) in the same cycle as clr_err: new errors win.
        x_conf = 1'b0; x_seq = 1'b1; x_tim = 1'b1; x_dir = 4'b0010;
        step(RED, RED, RED, RED, 1'b1, 1'b1, "clr_vs_err");
        clear_flags();
        step(RED, RED, RED, RED, 1'b1, 1'b1, "clr_all");
        // EW red->yellow directly, then yellow only 1 clock.
        x_seq = 1'b1; x_dir = 4'b0010;
        step(RED, YELLOW, RED, RED, 1'b0, 1'b1, "ew_red_to_yellow");
        x_tim = 1'b1;
        step(RED, RED, RED, RED, 1'b0, 1'b1, "ew_short_yellow");
        clear_flags();
        step(RED, RED, RED, RED, 1'b1, 1'b1, "clr_all");

        // SN illegal code for one clock, recovery through red with no sequence error.
        x_ill = 1'b1; x_dir = 4'b0100;
        step(RED, RED, ILLEGAL, RED, 1'b0, 1'b1, "sn_illegal");
        all_red("sn_recover");
        rot_dir(SN, "sn_normal");
        all_red("sn_normal");
        clear_flags();
        step(RED, RED, RED, RED, 1'b1, 1'b1, "clr_illegal");

        // Reset mid-green: history discarded, partial green afterwards untimed and uncounted.
        x_cnt = x_cnt + 8'd1;
        for (int i = 0; i < 5; i++) step(GREEN, RED, RED, RED, 1'b0, 1'b1, "pre_reset_green");
        x_cnt = 8'd0;
        step(GREEN, RED, RED, RED, 1'b0, 1'b0, "mid_reset");
        for (int i = 0; i < 4; i++) step(GREEN, RED, RED, RED, 1'b0, 1'b1, "post_reset_green");
        step(YELLOW, RED, RED, RED, 1'b0, 1'b1, "untimed_partial");
        step(YELLOW, RED, RED, RED, 1'b0, 1'b1, "untimed_partial");
        all_red("untimed_partial");

        // 256 NS-only cycles: counter passes 255 and wraps to 0.
        for (int k = 0; k < 256; k++) begin
            rot_dir(NS, "count_wrap");
            all_red("count_wrap");
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
